// File: rtl/fetch_unit_pkg.sv
// Shared processor definitions: opcode map, default word width and fetch state encoding.
package fetch_unit_pkg;

    localparam int DATA_W_DEFAULT = 9;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_IMM_FETCH,
        ST_IMM_LATCH,
        ST_EXEC,
        ST_HALTED
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_watchdog.sv
// Done-timeout watchdog: counts EXEC cycles without done and pulses expire on the last allowed cycle.
module fetch_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    assign expire = count_en && !clear && (count == LAST);

    // Count waiting cycles; restart from zero on done or once the limit has been hit.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear || expire) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: reads program words, hands ir/din to the control unit and waits for done.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              enable,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] din,
    output logic              run,
    input  logic              done,
    output logic              halted,
    output logic              error,
    output logic [CNT_W-1:0]  retired
);

    fetch_state_t state, next_state;

    logic [ADDR_W-1:0] pc;
    logic [2:0]        opcode;
    logic              wd_clear, wd_count, wd_expire;
    logic              load_ir, load_din, inc_pc;
    logic              set_run, clr_run, set_halt, set_err, inc_retired;

    assign mem_addr = pc;
    assign opcode   = mem_data[DATA_W-1 -: 3];

    fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock    (clock),
        .resetn   (resetn),
        .clear    (wd_clear),
        .count_en (wd_count),
        .expire   (wd_expire)
    );

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection; the opcode is taken straight from the word being latched.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (enable) next_state = ST_FETCH;
            ST_FETCH:     next_state = ST_LATCH;
            ST_LATCH: begin
                if (opcode == OP_MVI)       next_state = ST_IMM_FETCH;
                else if (opcode == OP_HALT) next_state = ST_HALTED;
                else                        next_state = ST_EXEC;
            end
            ST_IMM_FETCH: next_state = ST_IMM_LATCH;
            ST_IMM_LATCH: next_state = ST_EXEC;
            ST_EXEC: begin
                if (done)           next_state = enable ? ST_FETCH : ST_IDLE;
                else if (wd_expire) next_state = ST_HALTED;
            end
            ST_HALTED:    next_state = ST_HALTED;
            default:      next_state = ST_IDLE;
        endcase
    end

    // Per-state datapath strobes; done outranks a watchdog expiry on the same cycle.
    always_comb begin
        load_ir     = 1'b0;
        load_din    = 1'b0;
        inc_pc      = 1'b0;
        set_run     = 1'b0;
        clr_run     = 1'b0;
        set_halt    = 1'b0;
        set_err     = 1'b0;
        inc_retired = 1'b0;
        wd_clear    = 1'b0;
        wd_count    = 1'b0;
        case (state)
            ST_LATCH: begin
                load_ir = 1'b1;
                inc_pc  = 1'b1;
                if (opcode == OP_HALT)     set_halt = 1'b1;
                else if (opcode != OP_MVI) set_run  = 1'b1;
            end
            ST_IMM_LATCH: begin
                load_din = 1'b1;
                inc_pc   = 1'b1;
                set_run  = 1'b1;
            end
            ST_EXEC: begin
                if (done) begin
                    clr_run     = 1'b1;
                    inc_retired = 1'b1;
                    wd_clear    = 1'b1;
                end else begin
                    wd_count = 1'b1;
                    if (wd_expire) begin
                        clr_run = 1'b1;
                        set_err = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Registered datapath and status outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pc      <= '0;
            ir      <= '0;
            din     <= '0;
            run     <= 1'b0;
            halted  <= 1'b0;
            error   <= 1'b0;
            retired <= '0;
        end else begin
            if (load_ir)     ir  <= mem_data;
            if (load_din)    din <= mem_data;
            if (inc_pc)      pc  <= pc + ADDR_W'(1);
            if (set_run)     run <= 1'b1;
            else if (clr_run) run <= 1'b0;
            if (set_halt)    halted <= 1'b1;
            if (set_err)     error  <= 1'b1;
            if (inc_retired) retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit with a behavioural program-walk model.
module tb_fetch_unit;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic [4:0] mem_addr;
    logic [8:0] mem_data;
    logic [8:0] ir;
    logic [8:0] din;
    logic       run;
    logic       done = 1'b0;
    logic       halted;
    logic       error;
    logic [7:0] retired;

    typedef struct {
        logic [8:0] ir;
        logic [8:0] din;
        logic [4:0] pc;
        logic [7:0] retired;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [8:0] mem[32];
    logic [8:0] mdl_din;
    logic [2:0] first_op;
    bit         exp_halt;
    int         exp_pc;
    int         exp_count;
    int         checks = 0;
    int         errors = 0;
    bit         resp_en = 1'b0;
    int         dly_lo = 1;
    int         dly_hi = 1;
    logic       run_q = 1'b0;

    always #5 clock = ~clock;

    fetch_unit dut (
        .clock    (clock),
        .resetn   (resetn),
        .enable   (enable),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .ir       (ir),
        .din      (din),
        .run      (run),
        .done     (done),
        .halted   (halted),
        .error    (error),
        .retired  (retired)
    );

    // Synchronous-read program memory.
    always @(posedge clock) mem_data <= mem[mem_addr];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every rising edge of run must match the next scoreboard entry.
    always @(negedge clock) begin
        if (resetn && run && !run_q) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_run: got run=1 ir=%0h, expected no instruction", ir);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("sb_ir", ir, mon_e.ir);
                checkOutput("sb_din", din, mon_e.din);
                checkOutput("sb_pc", mem_addr, mon_e.pc);
                checkOutput("sb_retired", retired, mon_e.retired);
            end
        end
        run_q <= run;
    end

    // Control-unit stand-in: answers run with a one-cycle done after a random delay.
    initial begin
        forever begin
            @(negedge clock);
            if (run && resp_en) begin
                int d;
                d = $urandom_range(dly_hi, dly_lo);
                repeat (d) @(negedge clock);
                if (run && resp_en) begin
                    done = 1'b1;
                    @(negedge clock);
                    done = 1'b0;
                end
            end
        end
    end

    // Reference model: walk the program from address 0 the way the ISA defines it.
    task automatic build_expect(input int max_instr);
        int         p;
        logic [8:0] w;
        logic [2:0] op;
        exp_t       e;
        p = 0;
        exp_halt = 1'b0;
        exp_count = 0;
        first_op = mem[0][8:6];
        for (int n = 0; n < max_instr; n++) begin
            w = mem[p];
            op = w[8:6];
            p = (p + 1) % 32;
            if (op == 3'b111) begin
                exp_halt = 1'b1;
                break;
            end
            if (op == 3'b001) begin
                mdl_din = mem[p];
                p = (p + 1) % 32;
            end
            e.ir = w;
            e.din = mdl_din;
            e.pc = 5'(p);
            e.retired = 8'(n);
            sb.push_back(e);
            exp_count++;
        end
        exp_pc = p;
    endtask

    task automatic reset_dut();
        enable = 1'b0;
        done = 1'b0;
        resp_en = 1'b0;
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        sb.delete();
        mdl_din = '0;
        resetn = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 32; i++) mem[i] = 9'h1C0;
    endtask

    task automatic wait_run(input logic level, input int limit, input string name);
        int c;
        c = 0;
        while (run !== level && c < limit) begin
            @(negedge clock);
            c++;
        end
        checkOutput({name, "_wait_run"}, run, level);
    endtask

    // Run the loaded program to a HALT or to max_instr instructions, then check final state.
    task automatic applyStimulus(input string name, input int max_instr, input int lo, input int hi);
        int cyc;
        int first_lat;
        int exp_lat;
        bit ok;
        build_expect(max_instr);
        exp_lat = (exp_count == 0) ? -1 : ((first_op == 3'b001) ? 5 : 3);
        dly_lo = lo;
        dly_hi = hi;
        resp_en = 1'b1;
        enable = 1'b1;
        cyc = 0;
        first_lat = -1;
        ok = 1'b0;
        while (cyc < 4000 && !ok) begin
            @(negedge clock);
            cyc++;
            if (run && first_lat < 0) first_lat = cyc;
            if (exp_halt) ok = halted;
            else if (sb.size() == 0 && run) begin
                enable = 1'b0;
                ok = 1'b1;
            end
        end
        checkOutput({name, "_finished"}, 32'(ok), 1);
        if (exp_lat > 0) checkOutput({name, "_latency"}, first_lat, exp_lat);
        if (!exp_halt) wait_run(1'b0, 100, name);
        repeat (3) @(negedge clock);
        checkOutput({name, "_run"}, run, 0);
        checkOutput({name, "_retired"}, retired, exp_count);
        checkOutput({name, "_pc"}, mem_addr, exp_pc);
        checkOutput({name, "_halted"}, halted, 32'(exp_halt));
        checkOutput({name, "_error"}, error, 0);
        checkOutput({name, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int cnt;
        fill_halt();
        mdl_din = '0;

        // Reset values.
        reset_dut();
        checkOutput("rst_run", run, 0);
        checkOutput("rst_ir", ir, 0);
        checkOutput("rst_din", din, 0);
        checkOutput("rst_pc", mem_addr, 0);
        checkOutput("rst_retired", retired, 0);
        checkOutput("rst_halted", halted, 0);
        checkOutput("rst_error", error, 0);

        // Basic MVI.
        fill_halt();
        mem[0] = 9'h040;
        mem[1] = 9'h005;
        applyStimulus("mvi", 1, 2, 2);

        // Non-MVI sequence ending in HALT.
        reset_dut();
        fill_halt();
        mem[0] = 9'h080;
        mem[1] = 9'h0C1;
        mem[2] = 9'h1C0;
        applyStimulus("seq", 10, 3, 3);

        // Watchdog expiry.
        reset_dut();
        fill_halt();
        mem[0] = 9'h080;
        build_expect(1);
        resp_en = 1'b0;
        enable = 1'b1;
        wait_run(1'b1, 50, "wd");
        cnt = 0;
        while (run && cnt < 100) begin
            cnt++;
            @(negedge clock);
        end
        checkOutput("wd_run_cycles", cnt, 16);
        checkOutput("wd_error", error, 1);
        checkOutput("wd_run", run, 0);
        done = 1'b1;
        @(negedge clock);
        done = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("wd_late_done_retired", retired, 0);
        checkOutput("wd_late_done_error", error, 1);
        checkOutput("wd_late_done_run", run, 0);
        checkOutput("wd_pc_frozen", mem_addr, 1);
        checkOutput("wd_halted", halted, 0);

        // Enable dropped while executing.
        reset_dut();
        fill_halt();
        mem[0] = 9'h080;
        mem[1] = 9'h0C1;
        mem[2] = 9'h0A2;
        build_expect(10);
        dly_lo = 3;
        dly_hi = 3;
        resp_en = 1'b1;
        enable = 1'b1;
        wait_run(1'b1, 50, "en_first");
        enable = 1'b0;
        wait_run(1'b0, 50, "en_done");
        repeat (5) @(negedge clock);
        checkOutput("en_idle_run", run, 0);
        checkOutput("en_idle_retired", retired, 1);
        checkOutput("en_idle_pc", mem_addr, 1);
        enable = 1'b1;
        cnt = 0;
        while (!halted && cnt < 200) begin
            @(negedge clock);
            cnt++;
        end
        repeat (2) @(negedge clock);
        checkOutput("en_halted", halted, 1);
        checkOutput("en_retired", retired, exp_count);
        checkOutput("en_pc", mem_addr, exp_pc);
        checkOutput("en_run", run, 0);

        // pc wrap: MV walk to address 31, MVI there takes its immediate from address 0.
        reset_dut();
        mem[0] = 9'h005;
        for (int i = 1; i < 31; i++) mem[i] = 9'($urandom_range(0, 63));
        mem[31] = 9'h040 | 9'($urandom_range(0, 63));
        applyStimulus("wrap", 32, 1, 2);

        // Reset asserted mid-EXEC.
        reset_dut();
        fill_halt();
        mem[0] = 9'h091;
        mem[1] = 9'h0D2;
        mem[2] = 9'h0A3;
        build_expect(3);
        dly_lo = 2;
        dly_hi = 3;
        resp_en = 1'b1;
        enable = 1'b1;
        cnt = 0;
        while (!(sb.size() == 0 && run) && cnt < 200) begin
            @(negedge clock);
            cnt++;
        end
        resp_en = 1'b0;
        checkOutput("mid_reached_third", 32'(sb.size() == 0 && run), 1);
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        checkOutput("mid_rst_run", run, 0);
        checkOutput("mid_rst_ir", ir, 0);
        checkOutput("mid_rst_pc", mem_addr, 0);
        checkOutput("mid_rst_retired", retired, 0);
        reset_dut();
        applyStimulus("restart", 1, 1, 3);

        // Random programs.
        for (int t = 0; t < 4; t++) begin
            reset_dut();
            for (int i = 0; i < 32; i++) mem[i] = 9'($urandom_range(0, 511));
            applyStimulus($sformatf("rand%0d", t), 12, 1, 4);
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
